regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (we/wr/wd) between two writeback sources: ALU and load/memory.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/wb_skid_buf.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared writeback types and sizes for the register-file write path.
//   XLEN      : register data width
//   AW        : register index width
//   NREG      : number of architectural registers (2**AW)
//   wb_req_t  : one writeback request {rd, data}
//   wb_src_e  : writeback source identifier
//   rd_onehot : decode a register index into a one-hot register mask
package rv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic [NREG-1:0] rd_onehot(input logic [AW-1:0] rd);
    rd_onehot = NREG'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry holding buffer for a single writeback source.
//   clk, reset : clock, async active-high reset
//   valid      : source offers req this cycle
//   req        : offered {rd, data}
//   grant      : arbiter moves the held entry to the output stage this cycle
//   ready_c    : handshake ready (combinational)
//   full       : buffer holds an entry
//   entry      : held {rd, data}
//   load_c     : entry is captured at the coming edge (accept with rd != x0)
module wb_skid_buf
  import rv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    valid,
  input  wb_req_t req,
  input  logic    grant,
  output logic    ready_c,
  output logic    full,
  output wb_req_t entry,
  output logic    load_c
);

  // A granted entry leaves at the same edge, so the slot can be refilled without a bubble.
  assign ready_c = !full || grant;

  // x0 writes complete the handshake but are never stored.
  assign load_c  = valid && ready_c && (req.rd != '0);

  // Occupancy and payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (load_c) begin
      full  <= 1'b1;
      entry <= req;
    end else if (grant) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Oldest entry first; equal-age ties go round-robin, except same-rd ties
// which always drain ALU then MEM so the load result lands last.
//   clk, reset                         : clock, async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data: ALU writeback handshake
//   mem_valid/mem_ready/mem_rd/mem_data: load writeback handshake
//   rf_we/rf_wr/rf_wd                  : registered register-file write port
//   pending_mask                       : registers with an accepted, uncommitted write
module regfile_write_arbiter
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wr,
  output logic [XLEN-1:0] rf_wd,
  output logic [NREG-1:0] pending_mask
);

  wb_req_t alu_req, mem_req, alu_entry, mem_entry;
  logic    alu_full, mem_full, alu_load_c, mem_load_c;
  logic    alu_grant_c, mem_grant_c, rr_tie_c;
  logic    alu_older, mem_older;
  wb_src_e last_src;
  logic [NREG-1:0] pending_c;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};

  wb_skid_buf u_alu_buf (
    .clk     (clk),
    .reset   (reset),
    .valid   (alu_valid),
    .req     (alu_req),
    .grant   (alu_grant_c),
    .ready_c (alu_ready),
    .full    (alu_full),
    .entry   (alu_entry),
    .load_c  (alu_load_c)
  );

  wb_skid_buf u_mem_buf (
    .clk     (clk),
    .reset   (reset),
    .valid   (mem_valid),
    .req     (mem_req),
    .grant   (mem_grant_c),
    .ready_c (mem_ready),
    .full    (mem_full),
    .entry   (mem_entry),
    .load_c  (mem_load_c)
  );

  // Grant selection: age, then same-rd ordering, then round-robin.
  always_comb begin
    alu_grant_c = 1'b0;
    mem_grant_c = 1'b0;
    rr_tie_c    = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_older) begin
        alu_grant_c = 1'b1;
      end else if (mem_older) begin
        mem_grant_c = 1'b1;
      end else if (alu_entry.rd == mem_entry.rd) begin
        alu_grant_c = 1'b1;
      end else begin
        rr_tie_c = 1'b1;
        if (last_src == SRC_MEM) begin
          alu_grant_c = 1'b1;
        end else begin
          mem_grant_c = 1'b1;
        end
      end
    end else if (alu_full) begin
      alu_grant_c = 1'b1;
    end else if (mem_full) begin
      mem_grant_c = 1'b1;
    end
  end

  // Relative age: only meaningful while both buffers are full, and any
  // transition into that state passes through a load, which rewrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_older <= 1'b0;
      mem_older <= 1'b0;
    end else if (alu_load_c && mem_load_c) begin
      alu_older <= 1'b0;
      mem_older <= 1'b0;
    end else if (alu_load_c) begin
      alu_older <= 1'b0;
      mem_older <= mem_full && !mem_grant_c;
    end else if (mem_load_c) begin
      alu_older <= alu_full && !alu_grant_c;
      mem_older <= 1'b0;
    end
  end

  // Round-robin pointer advances only on a different-rd equal-age tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_src <= SRC_MEM;
    end else if (rr_tie_c) begin
      last_src <= alu_grant_c ? SRC_ALU : SRC_MEM;
    end
  end

  // Output stage; index and data hold while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wr <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= alu_grant_c || mem_grant_c;
      if (alu_grant_c) begin
        rf_wr <= alu_entry.rd;
        rf_wd <= alu_entry.data;
      end else if (mem_grant_c) begin
        rf_wr <= mem_entry.rd;
        rf_wd <= mem_entry.data;
      end
    end
  end

  // Outstanding writes: held entries plus the write presented to the register file.
  always_comb begin
    pending_c = '0;
    if (alu_full) pending_c = pending_c | rd_onehot(alu_entry.rd);
    if (mem_full) pending_c = pending_c | rd_onehot(mem_entry.rd);
    if (rf_we)    pending_c = pending_c | rd_onehot(rf_wr);
    pending_c[0] = 1'b0;
  end

  assign pending_mask = pending_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter driving a simple register file with readback.
module tb_regfile_write_arbiter;
  import rv_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid;
  logic            alu_ready, mem_ready;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            rf_we;
  logic [AW-1:0]   rf_wr;
  logic [XLEN-1:0] rf_wd;
  logic [NREG-1:0] pending_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rf_we        (rf_we),
    .rf_wr        (rf_wr),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask)
  );

  // Register file fed by the arbiter, with one read port.
  logic [XLEN-1:0] rf_mem [NREG] = '{default: '0};
  logic [AW-1:0]   ra1 = '0;
  logic [XLEN-1:0] rd1;
  always @(posedge clk) if (rf_we && rf_wr != '0) rf_mem[rf_wr] <= rf_wd;
  assign rd1 = (ra1 == '0) ? '0 : rf_mem[ra1];

  // Log of committed write indices and the cycle each was presented.
  int           cyc = 0;
  logic [AW-1:0] wlog[$];
  int           wcyc[$];
  always @(posedge clk) begin
    if (rf_we) begin
      wlog.push_back(rf_wr);
      wcyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries carry an unbounded timestamp; smaller is older.
  logic            mfull [2];
  logic [AW-1:0]   mrd   [2];
  logic [XLEN-1:0] mdata [2];
  int              mts   [2];
  int              ts_next;
  int              last_tie;
  logic            m_we;
  logic [AW-1:0]   m_wr;
  logic [XLEN-1:0] m_wd;
  int              cnt    [NREG];
  logic [XLEN-1:0] ref_rf [NREG] = '{default: '0};

  function automatic int model_grant();
    if (mfull[0] && mfull[1]) begin
      if (mts[0] < mts[1]) return 0;
      if (mts[1] < mts[0]) return 1;
      if (mrd[0] == mrd[1]) return 0;
      return (last_tie == 0) ? 1 : 0;
    end
    if (mfull[0]) return 0;
    if (mfull[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int   g;
    logic tie, acc0, acc1, loaded;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        mfull[s] = 1'b0; mrd[s] = '0; mdata[s] = '0; mts[s] = 0;
      end
      for (int r = 0; r < NREG; r++) cnt[r] = 0;
      ts_next = 0; last_tie = 1;
      m_we = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      g    = model_grant();
      tie  = mfull[0] && mfull[1] && (mts[0] == mts[1]) && (mrd[0] != mrd[1]);
      acc0 = alu_valid && (!mfull[0] || g == 0);
      acc1 = mem_valid && (!mfull[1] || g == 1);
      if (m_we) begin
        if (m_wr != '0) ref_rf[m_wr] = m_wd;
        cnt[m_wr]--;
      end
      m_we = (g >= 0);
      if (g >= 0) begin
        m_wr = mrd[g];
        m_wd = mdata[g];
        mfull[g] = 1'b0;
        if (tie) last_tie = g;
      end
      loaded = 1'b0;
      if (acc0 && alu_rd != '0) begin
        mfull[0] = 1'b1; mrd[0] = alu_rd; mdata[0] = alu_data; mts[0] = ts_next;
        cnt[alu_rd]++; loaded = 1'b1;
      end
      if (acc1 && mem_rd != '0) begin
        mfull[1] = 1'b1; mrd[1] = mem_rd; mdata[1] = mem_data; mts[1] = ts_next;
        cnt[mem_rd]++; loaded = 1'b1;
      end
      if (loaded) ts_next++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int              g;
    logic [NREG-1:0] pm;
    g = model_grant();
    pm = '0;
    for (int r = 1; r < NREG; r++) pm[r] = (cnt[r] > 0);
    chk("alu_ready", 64'(alu_ready), 64'(!mfull[0] || g == 0));
    chk("mem_ready", 64'(mem_ready), 64'(!mfull[1] || g == 1));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_wr", 64'(rf_wr), 64'(m_wr));
    chk("rf_wd", rf_wd, m_wd);
    chk("pending_mask", 64'(pending_mask), 64'(pm));
  end

  task automatic drive(input logic av, input int ard, input int ad,
                       input logic mv, input int mrd_i, input int md);
    alu_valid = av; alu_rd = AW'(ard); alu_data = XLEN'(ad);
    mem_valid = mv; mem_rd = AW'(mrd_i); mem_data = XLEN'(md);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic readback(input string name, input int r, input int exp);
    ra1 = AW'(r);
    #1;
    chk(name, rd1, XLEN'(exp));
  endtask

  initial begin
    int pend2, wes;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_rf_we", 64'(rf_we), 64'(0));
    chk("reset_pending", 64'(pending_mask), 64'(0));
    chk("reset_alu_ready", 64'(alu_ready), 64'(1));
    chk("reset_mem_ready", 64'(mem_ready), 64'(1));
    #9 reset = 1'b0;
    step();

    // ALU only write to x2.
    drive(1, 2, 10, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    pend2 = 0; wes = 0;
    repeat (4) begin
      @(negedge clk);
      pend2 += int'(pending_mask[2]);
      if (rf_we) begin
        wes++;
        chk("t1_wr", 64'(rf_wr), 64'(2));
        chk("t1_wd", rf_wd, 64'(10));
      end
    end
    chk("t1_pending_cycles", 64'(pend2), 64'(2));
    chk("t1_we_cycles", 64'(wes), 64'(1));
    step();
    readback("t1_x2", 2, 10);

    // Equal-age pair, twice: round-robin alternates.
    for (int k = 0; k < 2; k++) begin
      wlog.delete(); wcyc.delete();
      drive(1, 5, 7, 1, 6, 9);
      step();
      idle(4);
      chk("t2_count", 64'(wlog.size()), 64'(2));
      if (wlog.size() == 2) begin
        chk("t2_first", 64'(wlog[0]), 64'((k == 0) ? 5 : 6));
        chk("t2_second", 64'(wlog[1]), 64'((k == 0) ? 6 : 5));
      end
    end
    readback("t2_x5", 5, 7);
    readback("t2_x6", 6, 9);

    // Write to x0 is dropped.
    wlog.delete();
    drive(1, 0, 55, 0, 0, 0);
    #1 chk("t3_alu_ready", 64'(alu_ready), 64'(1));
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_rf_we", 64'(rf_we), 64'(0));
      chk("t3_pending", 64'(pending_mask), 64'(0));
    end
    step();
    chk("t3_no_writes", 64'(wlog.size()), 64'(0));
    readback("t3_x0", 0, 0);

    // Age ordering beats round-robin; same-rd tie drains ALU then MEM.
    wlog.delete();
    drive(1, 7, 3, 1, 12, 4);  step();
    drive(1, 13, 6, 0, 0, 0);  step();
    drive(0, 0, 0, 1, 3, 1);   step();
    drive(1, 4, 2, 0, 0, 0);   step();
    idle(4);
    chk("t4_count", 64'(wlog.size()), 64'(5));
    if (wlog.size() == 5) begin
      chk("t4_order0", 64'(wlog[0]), 64'(7));
      chk("t4_order1", 64'(wlog[1]), 64'(12));
      chk("t4_order2", 64'(wlog[2]), 64'(13));
      chk("t4_order3", 64'(wlog[3]), 64'(3));
      chk("t4_order4", 64'(wlog[4]), 64'(4));
    end
    drive(1, 8, 11, 1, 8, 22);
    step();
    idle(4);
    readback("t4_x8", 8, 22);
    readback("t4_x3", 3, 1);
    readback("t4_x4", 4, 2);

    // Back-to-back ALU stream.
    wlog.delete(); wcyc.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 16 + i, 100 + i, 0, 0, 0);
      #1 chk("t5_alu_ready", 64'(alu_ready), 64'(1));
      step();
    end
    idle(3);
    chk("t5_count", 64'(wlog.size()), 64'(8));
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t5_idx", 64'(wlog[i]), 64'(16 + i));
        chk("t5_cycle", 64'(wcyc[i] - wcyc[0]), 64'(i));
      end
    end
    for (int i = 0; i < 8; i++) readback("t5_reg", 16 + i, 100 + i);

    // Reset with both buffers full.
    drive(1, 24, 77, 1, 25, 88);
    step();
    drive(1, 26, 1, 1, 27, 2);
    #1 chk("t6_pre_pending", 64'(pending_mask != '0), 64'(1));
    #1 reset = 1'b1;
    #1;
    chk("t6_rf_we", 64'(rf_we), 64'(0));
    chk("t6_pending", 64'(pending_mask), 64'(0));
    chk("t6_alu_ready", 64'(alu_ready), 64'(1));
    chk("t6_mem_ready", 64'(mem_ready), 64'(1));
    drive(0, 0, 0, 0, 0, 0);
    wlog.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    idle(4);
    chk("t6_no_writes", 64'(wlog.size()), 64'(0));
    readback("t6_x24", 24, 0);
    readback("t6_x25", 25, 0);
    readback("t6_x26", 26, 0);

    // Whole register file against the model's view.
    for (int r = 0; r < NREG; r++) begin
      ra1 = AW'(r);
      #1 chk("final_reg", rd1, ref_rf[r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
